// File: rtl/mem_map_pkg.sv
// Shared address map, size/error encodings and controller state enum for the
// data-memory responder.
package mem_map_pkg;

    localparam logic [31:0] GP_BASE  = 32'h1001_0000;
    localparam logic [31:0] GP_LIMIT = 32'h1001_0FFF;
    localparam logic [31:0] SP_BASE  = 32'h7FFF_F000;
    localparam logic [31:0] SP_LIMIT = 32'h7FFF_FFFF;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_UNMAPPED = 2'b01;
    localparam logic [1:0] ERR_MISALIGN = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RDW,
        S_WR,
        S_RESP
    } state_e;

    // The reserved encoding 2'b11 behaves exactly like a word access.
    function automatic logic is_word(input logic [1:0] sz);
        return sz[1];
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Little-endian lane logic: load extraction with zero/sign extension, and the
// merge of a right-aligned sub-word store into the word read back from RAM.
module mem_lane_unit
    import mem_map_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        signext_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
        half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        load_o   = rdata_i;
        merge_o  = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_o  = {{24{signext_i & byte_sel[7]}}, byte_sel};
                merge_o = rdata_i;
                merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_o  = {{16{signext_i & half_sel[15]}}, half_sel};
                merge_o = rdata_i;
                merge_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: begin
                load_o  = rdata_i;
                merge_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-outstanding data-memory controller: address translation, fault check,
// synchronous-read RAM sequencing and read-modify-write for sub-word stores.
module data_mem_ctrl
    import mem_map_pkg::*;
#(
    parameter int PADDR_W = 11,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    // Handshake: a request transfers on a rising edge where req_valid && req_ready.
    // req_ready is high only in IDLE; request inputs are ignored at all other times.
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [1:0]         req_size,
    input  logic               req_signext,
    input  logic [31:0]        req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
    output logic               resp_valid,
    output logic [DATA_W-1:0]  resp_rdata,
    output logic [1:0]         resp_err,
    output logic [PADDR_W-1:0] mem_addr,
    output logic               mem_re,
    output logic               mem_we,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output state_e             dbg_state_o
);

    state_e              state_q, state_d;
    logic [1:0]          size_q, size_d;
    logic [1:0]          lane_q, lane_d;
    logic                signext_q, signext_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [PADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic [1:0]          resp_err_q, resp_err_d;
    logic                mem_re_q, mem_we_q, resp_valid_q;

    logic                in_gp, in_sp, misalign;
    logic [1:0]          req_err;
    logic [PADDR_W-1:0]  phys_idx;
    logic [DATA_W-1:0]   load_data, merge_data;

    // The stack region occupies the upper half of the RAM, so its hit bit is the index MSB.
    always_comb begin
        in_gp    = (req_addr >= GP_BASE) && (req_addr <= GP_LIMIT);
        in_sp    = (req_addr >= SP_BASE) && (req_addr <= SP_LIMIT);
        misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                   (is_word(req_size) && (req_addr[1:0] != 2'b00));
        if (!(in_gp || in_sp)) begin
            req_err = ERR_UNMAPPED;
        end else if (misalign) begin
            req_err = ERR_MISALIGN;
        end else begin
            req_err = ERR_OK;
        end
        phys_idx = PADDR_W'({in_sp, req_addr[11:2]});
    end

    mem_lane_unit u_lane (
        .rdata_i   (mem_rdata),
        .wdata_i   (wdata_q),
        .lane_i    (lane_q),
        .size_i    (size_q),
        .signext_i (signext_q),
        .load_o    (load_data),
        .merge_o   (merge_data)
    );

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        lane_d       = lane_q;
        signext_d    = signext_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    size_d    = req_size;
                    lane_d    = req_addr[1:0];
                    signext_d = req_signext;
                    write_d   = req_write;
                    wdata_d   = req_wdata;
                    if (req_err != ERR_OK) begin
                        resp_err_d   = req_err;
                        resp_rdata_d = '0;
                        state_d      = S_RESP;
                    end else begin
                        mem_addr_d = phys_idx;
                        if (req_write && is_word(req_size)) begin
                            mem_wdata_d = req_wdata;
                            state_d     = S_WR;
                        end else begin
                            state_d = S_RD;
                        end
                    end
                end
            end
            S_RD: state_d = S_RDW;
            S_RDW: begin
                if (write_q) begin
                    mem_wdata_d = merge_data;
                    state_d     = S_WR;
                end else begin
                    resp_rdata_d = load_data;
                    resp_err_d   = ERR_OK;
                    state_d      = S_RESP;
                end
            end
            S_WR: begin
                resp_rdata_d = '0;
                resp_err_d   = ERR_OK;
                state_d      = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            size_q       <= SZ_BYTE;
            lane_q       <= 2'b00;
            signext_q    <= 1'b0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= ERR_OK;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            lane_q       <= lane_d;
            signext_q    <= signext_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_re_q     <= (state_d == S_RD);
            mem_we_q     <= (state_d == S_WR);
            resp_valid_q <= (state_d == S_RESP);
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign mem_addr    = mem_addr_q;
    assign mem_re      = mem_re_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a behavioural RAM, a response scoreboard
// and a RAM-access scoreboard, both keyed by the expected cycle.
module tb_data_mem_ctrl;
  import mem_map_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signext;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [10:0] mem_addr;
  logic        mem_re, mem_we;
  logic [31:0] mem_wdata, mem_rdata;
  state_e      dbg_state;

  logic [31:0] ram [2048];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // {cycle, err, rdata}
  logic [65:0] exp_resp_q[$];
  // {cycle, re, we, addr, wdata}
  logic [76:0] exp_mem_q[$];

  data_mem_ctrl #(.PADDR_W(11), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signext (req_signext),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .dbg_state_o (dbg_state)
  );

  // clock / cycle counter / synchronous-read RAM
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // response monitor
  always @(negedge clk) begin : resp_mon
    logic [65:0] e;
    logic [65:0] a;
    if (resp_valid === 1'b1) begin
      checks++;
      a = {32'(cyc), resp_err, resp_rdata};
      if (exp_resp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected actual cyc=%0d err=%b rdata=%h expected none", cyc, resp_err, resp_rdata);
      end else begin
        e = exp_resp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL resp actual cyc=%0d err=%b rdata=%h expected cyc=%0d err=%b rdata=%h",
                   cyc, resp_err, resp_rdata, e[65:34], e[33:32], e[31:0]);
        end
      end
    end
  end

  // RAM access monitor
  always @(negedge clk) begin : mem_mon
    logic [76:0] e;
    logic [76:0] a;
    if (mem_re === 1'b1 || mem_we === 1'b1) begin
      checks++;
      a = {32'(cyc), mem_re, mem_we, mem_addr, (mem_we ? mem_wdata : 32'h0)};
      if (exp_mem_q.size() == 0) begin
        errors++;
        $display("FAIL mem_unexpected actual cyc=%0d re=%b we=%b addr=%0d wdata=%h expected none",
                 cyc, mem_re, mem_we, mem_addr, mem_wdata);
      end else begin
        e = exp_mem_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL mem actual cyc=%0d re=%b we=%b addr=%0d wdata=%h expected cyc=%0d re=%b we=%b addr=%0d wdata=%h",
                   cyc, mem_re, mem_we, mem_addr, a[31:0], e[76:45], e[44], e[43], e[42:32], e[31:0]);
        end
      end
    end
  end

  // driver: issues one request and pushes the hand-computed expectations
  task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] e_err, input logic [31:0] e_rd,
                       input logic [10:0] e_idx, input logic [31:0] e_wword,
                       input bit no_resp, input bit hold);
    int t;
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_size = sz;
    req_signext = sx;
    req_addr = a;
    req_wdata = wd;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout actual=%b expected=1", req_ready);
      req_valid = 1'b0;
      return;
    end
    t = cyc;
    if (e_err != ERR_OK) begin
      if (!no_resp) exp_resp_q.push_back({32'(t + 1), e_err, 32'h0});
    end else if (w && sz[1]) begin
      exp_mem_q.push_back({32'(t + 1), 1'b0, 1'b1, e_idx, e_wword});
      if (!no_resp) exp_resp_q.push_back({32'(t + 2), ERR_OK, 32'h0});
    end else begin
      exp_mem_q.push_back({32'(t + 1), 1'b1, 1'b0, e_idx, 32'h0});
      if (w) begin
        exp_mem_q.push_back({32'(t + 3), 1'b0, 1'b1, e_idx, e_wword});
        if (!no_resp) exp_resp_q.push_back({32'(t + 4), ERR_OK, 32'h0});
      end else begin
        if (!no_resp) exp_resp_q.push_back({32'(t + 3), ERR_OK, e_rd});
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      chk("hold_ready_t1", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("hold_ready_t2", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("hold_ready_t3", 32'(req_ready), 32'd1);
    end
    req_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = SZ_WORD;
    req_signext = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    mem_rdata = 32'h0;
    for (int i = 0; i < 2048; i++) ram[i] = 32'h0;
    ram[0]    = 32'h80FF_0000;
    ram[2]    = 32'hDEAD_BEEF;
    ram[1023] = 32'hCAFE_F00D;
    ram[1024] = 32'h0BAD_C0DE;
    ram[1025] = 32'h1122_3344;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0;

    //     w     size     sx    addr           wdata          err           rdata          idx       wword        nr hold
    issue(1'b0, SZ_WORD, 1'b0, 32'h1001_0008, 32'h0,         ERR_OK,       32'hDEAD_BEEF, 11'd2,    32'h0,        0, 0);
    issue(1'b1, SZ_BYTE, 1'b0, 32'h7FFF_F005, 32'h0000_00AB, ERR_OK,       32'h0,         11'd1025, 32'h1122_AB44, 0, 0);
    issue(1'b0, SZ_BYTE, 1'b1, 32'h1001_0003, 32'h0,         ERR_OK,       32'hFFFF_FF80, 11'd0,    32'h0,        0, 0);
    issue(1'b0, SZ_BYTE, 1'b0, 32'h1001_0003, 32'h0,         ERR_OK,       32'h0000_0080, 11'd0,    32'h0,        0, 0);
    issue(1'b1, SZ_WORD, 1'b0, 32'h1001_1000, 32'h5555_5555, ERR_UNMAPPED, 32'h0,         11'd0,    32'h0,        0, 0);
    issue(1'b0, SZ_HALF, 1'b0, 32'h1001_0001, 32'h0,         ERR_MISALIGN, 32'h0,         11'd0,    32'h0,        0, 0);
    issue(1'b1, SZ_WORD, 1'b0, 32'h7FFF_FFFC, 32'h1234_5678, ERR_OK,       32'h0,         11'd2047, 32'h1234_5678, 0, 1);
    issue(1'b0, SZ_WORD, 1'b0, 32'h7FFF_FFFC, 32'h0,         ERR_OK,       32'h1234_5678, 11'd2047, 32'h0,        0, 0);
    issue(1'b0, SZ_HALF, 1'b1, 32'h1001_0002, 32'h0,         ERR_OK,       32'hFFFF_80FF, 11'd0,    32'h0,        0, 0);
    issue(1'b0, SZ_HALF, 1'b0, 32'h1001_0002, 32'h0,         ERR_OK,       32'h0000_80FF, 11'd0,    32'h0,        0, 0);
    issue(1'b1, SZ_HALF, 1'b0, 32'h1001_0000, 32'hAAAA_BEEF, ERR_OK,       32'h0,         11'd0,    32'h80FF_BEEF, 0, 0);
    issue(1'b0, SZ_WORD, 1'b0, 32'h1001_0000, 32'h0,         ERR_OK,       32'h80FF_BEEF, 11'd0,    32'h0,        0, 0);
    issue(1'b0, SZ_WORD, 1'b0, 32'h1001_0FFC, 32'h0,         ERR_OK,       32'hCAFE_F00D, 11'd1023, 32'h0,        0, 0);
    issue(1'b0, SZ_WORD, 1'b0, 32'h7FFF_F000, 32'h0,         ERR_OK,       32'h0BAD_C0DE, 11'd1024, 32'h0,        0, 0);
    issue(1'b0, SZ_WORD, 1'b0, 32'h1000_FFFC, 32'h0,         ERR_UNMAPPED, 32'h0,         11'd0,    32'h0,        0, 0);
    issue(1'b0, 2'b11,   1'b0, 32'h1001_0002, 32'h0,         ERR_MISALIGN, 32'h0,         11'd0,    32'h0,        0, 0);
    issue(1'b0, SZ_HALF, 1'b0, 32'h1001_1001, 32'h0,         ERR_UNMAPPED, 32'h0,         11'd0,    32'h0,        0, 0);
    issue(1'b0, SZ_WORD, 1'b1, 32'h1001_0008, 32'h0,         ERR_OK,       32'hDEAD_BEEF, 11'd2,    32'h0,        0, 0);
    issue(1'b1, SZ_BYTE, 1'b0, 32'h7FFF_FFFF, 32'h0000_01FF, ERR_OK,       32'h0,         11'd2047, 32'hFF34_5678, 0, 0);
    issue(1'b0, SZ_WORD, 1'b0, 32'h7FFF_FFFC, 32'h0,         ERR_OK,       32'hFF34_5678, 11'd2047, 32'h0,        0, 0);

    // reset during the RDW cycle of a load: no response and no further RAM access
    issue(1'b0, SZ_WORD, 1'b0, 32'h1001_0008, 32'h0,         ERR_OK,       32'h0,         11'd2,    32'h0,        1, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", 32'(dbg_state), 32'(S_IDLE));
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    repeat (6) @(negedge clk);

    n = 0;
    while ((exp_resp_q.size() != 0 || exp_mem_q.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("leftover_resp", 32'(exp_resp_q.size()), 32'd0);
    chk("leftover_mem", 32'(exp_mem_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
